// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial add sequencer that time-shares one external FullAdder cell to
//   add two WIDTH-bit operands, LSB first, one bit per clock. Operands and the
//   initial carry are captured on Start; each RUN cycle presents one bit pair
//   plus the running carry to the shared cell and collects its Sum/Cout.
//   {Cout, Result} = OpA + OpB + CinIn, reported with a one-cycle Done pulse.
//
// Ports:
//   Clk, Reset         clock, synchronous active-high reset
//   Start              request, only honoured in IDLE
//   OpA, OpB, CinIn    operands and carry-in, captured with an accepted Start
//   FA_A, FA_B, FA_Cin drive the shared FullAdder inputs (0 outside RUN)
//   FA_Sum, FA_Cout    combinational outputs of the shared FullAdder
//   Busy               high while bits are being added
//   Done               one-cycle completion pulse
//   Result, Cout       sum and carry-out, valid from Done until the next Start
//   Overflow           two's-complement overflow, same validity as Result
//                      (only present when SERIAL_ADDER_OVERFLOW_EN is defined)
//
// Configuration macro: SERIAL_ADDER_OVERFLOW_EN

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             CinIn,
  output logic             FA_A,
  output logic             FA_B,
  output logic             FA_Cin,
  input  logic             FA_Sum,
  input  logic             FA_Cout,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Cout
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             Overflow
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [WIDTH-1:0] opa_sr;
  logic [WIDTH-1:0] opb_sr;
  logic             carry;
  logic [CW-1:0]    count;
  logic             last_bit;

  // The bit being added this cycle is the MSB once count reaches WIDTH-1.
  assign last_bit = (count == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the combinational outputs. The shared adder only
  // sees live data during RUN so it stays quiet while idle or reporting.
  always_comb begin
    state_next = state;
    FA_A       = 1'b0;
    FA_B       = 1'b0;
    FA_Cin     = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        Busy   = 1'b1;
        FA_A   = opa_sr[0];
        FA_B   = opb_sr[0];
        FA_Cin = carry;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath. Sum bits enter the accumulator at the MSB end so that after
  // WIDTH shifts the first (LSB) sum bit has reached Result[0]. Result and
  // Cout are left untouched on Start; they simply get overwritten during RUN.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      opa_sr   <= '0;
      opb_sr   <= '0;
      carry    <= 1'b0;
      count    <= '0;
      Result   <= '0;
      Cout     <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      Overflow <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            opa_sr <= OpA;
            opb_sr <= OpB;
            carry  <= CinIn;
            count  <= '0;
          end
        end
        RUN: begin
          Result <= {FA_Sum, Result[WIDTH-1:1]};
          carry  <= FA_Cout;
          opa_sr <= {1'b0, opa_sr[WIDTH-1:1]};
          opb_sr <= {1'b0, opb_sr[WIDTH-1:1]};
          count  <= count + CW'(1);
          if (last_bit) begin
            Cout     <= FA_Cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            // carry is the carry into the MSB cell during the last bit.
            Overflow <= carry ^ FA_Cout;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
